// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller:
// forward selects, load result-source code and memory-wait FSM states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic {
    HZ_RUN,
    HZ_WAIT
  } hz_state_t;

endpackage

// File: rtl/hazard_forward.sv
// Single-operand forward select for the execute stage.
// The memory stage wins over writeback; x0 is never forwarded.
module hazard_forward
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] rs_e_i,
  input  logic [AW-1:0] rd_m_i,
  input  logic [AW-1:0] rd_w_i,
  input  logic          reg_write_m_i,
  input  logic          reg_write_w_i,
  output fwd_sel_t      fwd_o
);

  logic hit_m;
  logic hit_w;

  assign hit_m = reg_write_m_i && (rd_m_i != '0)
                 && (rd_m_i == rs_e_i);
  assign hit_w = reg_write_w_i && (rd_w_i != '0)
                 && (rd_w_i == rs_e_i);

  always_comb begin
    fwd_o = FWD_RF;
    if (hit_m)      fwd_o = FWD_MEM;
    else if (hit_w) fwd_o = FWD_WB;
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush/forward control for the 5-stage core, with a
// data-memory wait FSM, timeout flag and saturating perf counters.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic [1:0]                ResultSrcE,
  input  logic                      PCSrcE,
  input  logic                      MemReqM,
  input  logic                      MemReadyM,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      mem_timeout,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] WMAX  = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WLAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [WW-1:0] WONE  = WW'(1);
  localparam logic [CNT_WIDTH-1:0] CONE = CNT_WIDTH'(1);

  fwd_sel_t fwd_a;
  fwd_sel_t fwd_b;

  hazard_forward #(.AW(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_e_i        (Rs1E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (fwd_a)
  );

  hazard_forward #(.AW(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_e_i        (Rs2E),
    .rd_m_i        (RdM),
    .rd_w_i        (RdW),
    .reg_write_m_i (RegWriteM),
    .reg_write_w_i (RegWriteW),
    .fwd_o         (fwd_b)
  );

  assign ForwardAE = rst ? FWD_RF : fwd_a;
  assign ForwardBE = rst ? FWD_RF : fwd_b;

  logic mem_stall;
  logic lw_stall;

  assign mem_stall = MemReqM && !MemReadyM;
  assign lw_stall  = (ResultSrcE == RESULT_SRC_LOAD)
                     && (RdE != '0)
                     && ((RdE == Rs1D) || (RdE == Rs2D));

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (rst) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
    end else if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  hz_state_t      state_q, state_d;
  logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
  logic           timeout_q, timeout_d;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    timeout_d  = timeout_q;
    unique case (state_q)
      HZ_RUN: begin
        if (mem_stall) state_d = HZ_WAIT;
      end
      HZ_WAIT: begin
        if (MemReadyM) begin
          state_d = HZ_RUN;
        end else begin
          wait_cnt_d = (wait_cnt_q == WMAX) ? wait_cnt_q
                                            : wait_cnt_q + WONE;
          if (wait_cnt_q == WLAST) timeout_d = 1'b1;
        end
      end
    endcase
  end

  logic                 any_stall;
  logic                 any_flush;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  assign any_stall = StallF || StallD || StallE || StallM;
  assign any_flush = FlushD || FlushE;

  assign stall_cnt_d = (any_stall && (stall_cnt_q != '1))
                       ? stall_cnt_q + CONE : stall_cnt_q;
  assign flush_cnt_d = (any_flush && (flush_cnt_q != '1))
                       ? flush_cnt_q + CONE : flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HZ_RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
